input_interface: RTL

Receive-side command front end for the vector coprocessor, between the UART receiver and the vector BRAMs/processing core. It decodes host command bytes and streams vector payloads into BRAM A or B as one write per received byte. For operation commands it drives the one-hot enables and a start pulse consumed by `outputInterface`. It holds off new commands until the result transmission completes.

---
 rtl/coproc_pkg.sv | 34 +++
 rtl/payload_counter.sv | 47 ++++
 rtl/input_interface.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/coproc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | coproc_pkg : opcodes, enable-bit indices and FSM state type shared    |
// |              by the vector coprocessor front end.   Rev 1.0           |
// +----------------------------------------------------------------------+
package coproc_pkg;

   localparam int EN_WIDTH = 6;

   localparam logic [7:0] OP_WRITE_A = 8'h01;
   localparam logic [7:0] OP_WRITE_B = 8'h02;
   localparam logic [7:0] OP_READ_A  = 8'h03;
   localparam logic [7:0] OP_READ_B  = 8'h04;
   localparam logic [7:0] OP_SUM     = 8'h05;
   localparam logic [7:0] OP_AVG     = 8'h06;
   localparam logic [7:0] OP_MAN     = 8'h07;
   localparam logic [7:0] OP_EUC     = 8'h08;

   localparam int EN_READ_A = 0;
   localparam int EN_READ_B = 1;
   localparam int EN_SUM    = 2;
   localparam int EN_EUC    = 3;
   localparam int EN_AVG    = 4;
   localparam int EN_MAN    = 5;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WRITE_DATA = 2'd1,
      ST_ISSUE      = 2'd2,
      ST_WAIT_SENT  = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/payload_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | payload_counter : payload address counter plus inter-byte idle timer. |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module payload_counter #(
   parameter int N_ELEMENTS     = 1024,
   parameter int ADDR_WIDTH     = $clog2(N_ELEMENTS),
   parameter int TIMEOUT_CYCLES = 100_000_000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_clear,
   input  logic                  i_inc,
   input  logic                  i_tick,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic                  o_last,
   output logic                  o_timeout
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   // One spare address bit so N_ELEMENTS itself is representable.
   logic [ADDR_WIDTH:0] r_addr;
   logic [TW-1:0]       r_tcnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_addr <= '0;
         r_tcnt <= '0;
      end else if (i_clear) begin
         r_addr <= '0;
         r_tcnt <= '0;
      end else if (i_inc) begin
         r_addr <= r_addr + (ADDR_WIDTH+1)'(1);
         r_tcnt <= '0;
      end else if (i_tick) begin
         r_tcnt <= r_tcnt + TW'(1);
      end
   end

   assign o_addr    = r_addr[ADDR_WIDTH-1:0];
   assign o_last    = (r_addr == (ADDR_WIDTH+1)'(N_ELEMENTS - 1));
   assign o_timeout = (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/input_interface.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | input_interface : host command decoder and vector payload writer.     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module input_interface
   import coproc_pkg::*;
#(
   parameter int N_ELEMENTS     = 1024,
   parameter int ADDR_WIDTH     = $clog2(N_ELEMENTS),
   parameter int TIMEOUT_CYCLES = 100_000_000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            rx_data,
   input  logic                  rx_ready,
   input  logic                  tx_sent,
   output logic                  wr_en_a,
   output logic                  wr_en_b,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [7:0]            wr_data,
   output logic [EN_WIDTH-1:0]   enables_out,
   output logic                  begin_transmission,
   output logic                  write_done,
   output logic                  cmd_error
);

   state_t                r_state;
   logic                  r_target_b;
   logic                  w_is_write;
   logic                  w_is_op;
   logic [EN_WIDTH-1:0]   w_enables;
   logic                  w_clear;
   logic                  w_inc;
   logic                  w_tick;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic                  w_last;
   logic                  w_timeout;

   always_comb begin
      w_is_write = 1'b0;
      w_is_op    = 1'b1;
      w_enables  = '0;
      case (rx_data)
         OP_WRITE_A, OP_WRITE_B: begin
            w_is_write = 1'b1;
            w_is_op    = 1'b0;
         end
         OP_READ_A: w_enables[EN_READ_A] = 1'b1;
         OP_READ_B: w_enables[EN_READ_B] = 1'b1;
         OP_SUM:    w_enables[EN_SUM]    = 1'b1;
         OP_EUC:    w_enables[EN_EUC]    = 1'b1;
         OP_AVG:    w_enables[EN_AVG]    = 1'b1;
         OP_MAN:    w_enables[EN_MAN]    = 1'b1;
         default:   w_is_op = 1'b0;
      endcase
   end

   assign w_clear = (r_state == ST_IDLE) && rx_ready && w_is_write;
   assign w_inc   = (r_state == ST_WRITE_DATA) && rx_ready;
   assign w_tick  = (r_state == ST_WRITE_DATA) && !rx_ready;

   payload_counter #(
      .N_ELEMENTS     (N_ELEMENTS),
      .ADDR_WIDTH     (ADDR_WIDTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_payload_counter (
      .clk       (clk),
      .reset     (reset),
      .i_clear   (w_clear),
      .i_inc     (w_inc),
      .i_tick    (w_tick),
      .o_addr    (w_addr),
      .o_last    (w_last),
      .o_timeout (w_timeout)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state            <= ST_IDLE;
         r_target_b         <= 1'b0;
         wr_en_a            <= 1'b0;
         wr_en_b            <= 1'b0;
         wr_addr            <= '0;
         wr_data            <= '0;
         enables_out        <= '0;
         begin_transmission <= 1'b0;
         write_done         <= 1'b0;
         cmd_error          <= 1'b0;
      end else begin
         wr_en_a            <= 1'b0;
         wr_en_b            <= 1'b0;
         begin_transmission <= 1'b0;
         write_done         <= 1'b0;
         cmd_error          <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (rx_ready) begin
                  if (w_is_write) begin
                     r_target_b <= (rx_data == OP_WRITE_B);
                     r_state    <= ST_WRITE_DATA;
                  end else if (w_is_op) begin
                     enables_out <= w_enables;
                     r_state     <= ST_ISSUE;
                  end else begin
                     cmd_error <= 1'b1;
                  end
               end
            end
            // A byte arriving on the expiry cycle wins over the timeout.
            ST_WRITE_DATA: begin
               if (rx_ready) begin
                  wr_data <= rx_data;
                  wr_addr <= w_addr;
                  wr_en_a <= !r_target_b;
                  wr_en_b <= r_target_b;
                  if (w_last) begin
                     write_done <= 1'b1;
                     r_state    <= ST_IDLE;
                  end
               end else if (w_timeout) begin
                  cmd_error <= 1'b1;
                  r_state   <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               begin_transmission <= 1'b1;
               r_state            <= ST_WAIT_SENT;
            end
            ST_WAIT_SENT: begin
               if (rx_ready) begin
                  cmd_error <= 1'b1;
               end
               if (tx_sent) begin
                  enables_out <= '0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
